// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM states and the
// latched command captured when a port is selected.
package dmem_arb_pkg;
  localparam int NUM_PORTS = 2;
  localparam int DMEM_AW   = 32;
  localparam int DMEM_DW   = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
    logic               owner;
  } cmd_t;
endpackage

// File: rtl/rr_select_2.sv
// Combinational two-requester round-robin picker: a lone request wins,
// a tie goes to the port that was not served last.
module rr_select_2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       valid,
  output logic       owner
);
  assign valid = |req;
  assign owner = (req == 2'b11) ? ~last_owner : req[1];
endmodule

// File: rtl/dmem_arbiter_32.sv
// Round-robin arbiter/sequencer sharing one data_mem_32 port between the
// CPU path (port 0) and the loader/debug path (port 1).
module dmem_arbiter_32
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_AW,
  parameter int DATA_WIDTH = DMEM_DW,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [1:0]            rerr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_enable,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  last_owner_q, last_owner_d;
  logic                  oor_q, oor_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [1:0]            rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  en_q, en_d, rd_q, rd_d, wr_q, wr_d;

  logic                  sel_valid, sel_owner, rr_last, latch;
  logic                  sel_we, sel_oor;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // In RESP the access being retired already counts as the last owner.
  assign rr_last = (state_q == RESP) ? cmd_q.owner : last_owner_q;

  rr_select_2 u_sel (
    .req        (req),
    .last_owner (rr_last),
    .valid      (sel_valid),
    .owner      (sel_owner)
  );

  assign sel_we    = we[sel_owner];
  assign sel_addr  = sel_owner ? addr1 : addr0;
  assign sel_wdata = sel_owner ? wdata1 : wdata0;
  assign sel_oor   = (sel_addr >= ADDR_WIDTH'(MEM_DEPTH));

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    last_owner_d = last_owner_q;
    oor_d        = oor_q;
    gnt_d        = '0;
    rvalid_d     = '0;
    rerr_d       = '0;
    rdata_d      = rdata_q;
    en_d         = 1'b0;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    latch        = 1'b0;
    case (state_q)
      IDLE: latch = sel_valid;
      ACCESS: begin
        state_d                = RESP;
        rvalid_d[cmd_q.owner]  = 1'b1;
        rerr_d[cmd_q.owner]    = oor_q;
        rdata_d = (!cmd_q.we && !oor_q) ? mem_rdata : '0;
      end
      RESP: begin
        last_owner_d = cmd_q.owner;
        latch        = sel_valid;
        if (!sel_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are computed one cycle early so ACCESS sees them straight
    // from flops and mem_write cannot glitch.
    if (latch) begin
      state_d          = ACCESS;
      cmd_d.we         = sel_we;
      cmd_d.addr       = sel_addr;
      cmd_d.wdata      = sel_wdata;
      cmd_d.owner      = sel_owner;
      oor_d            = sel_oor;
      gnt_d[sel_owner] = 1'b1;
      en_d             = 1'b1;
      rd_d             = !sel_we && !sel_oor;
      wr_d             = sel_we && !sel_oor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      last_owner_q <= 1'b1;
      oor_q        <= 1'b0;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      rerr_q       <= '0;
      rdata_q      <= '0;
      en_q         <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      last_owner_q <= last_owner_d;
      oor_q        <= oor_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      rerr_q       <= rerr_d;
      rdata_q      <= rdata_d;
      en_q         <= en_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  assign gnt        = gnt_q;
  assign rvalid     = rvalid_q;
  assign rerr       = rerr_q;
  assign rdata      = rdata_q;
  assign mem_enable = en_q;
  assign mem_read   = rd_q;
  assign mem_write  = wr_q;
  assign mem_addr   = cmd_q.addr;
  assign mem_wdata  = cmd_q.wdata;
endmodule
